mem_requester: RTL and testbench

- Initiator side of the single-port word memory interface.
- Accepts load/store requests from the pipeline on a valid/ready channel and sequences them onto the memory's `addr`/`wdata`/`wen`/`rdata` port.
- Returns load data on a valid/ready response channel.
- Optionally expands one load request into a multi-word burst with incrementing addresses.

---
 rtl/mem_requester_pkg.sv | 18 +
 rtl/mem_requester_if.sv | 37 +++
 rtl/mem_requester.sv | 87 ++++++++
 tb/tb_mem_requester.sv | 226 ++++++++++++++++++++++
 4 files changed

// File: rtl/mem_requester_pkg.sv
// Shared types and constants for the memory requester and the word memory it drives.
package mem_requester_pkg;

   localparam int unsigned MEM_ADDR_SIZE = 5;
   localparam int unsigned MEM_WORD_SIZE = 32;
   localparam int unsigned MEM_LEN_SIZE  = 3;

   localparam logic OP_LOAD  = 1'b0;
   localparam logic OP_STORE = 1'b1;

   typedef enum logic [1:0] {
      StIdle,
      StWrite,
      StRead,
      StResp
   } state_e;

endpackage

// File: rtl/mem_requester_if.sv
// Request/response channels plus the single-port memory bus of the requester.
interface mem_requester_if
   import mem_requester_pkg::*;
#(
   parameter int unsigned ADDR_SIZE = MEM_ADDR_SIZE,
   parameter int unsigned WORD_SIZE = MEM_WORD_SIZE,
   parameter int unsigned LEN_SIZE  = MEM_LEN_SIZE
);

   logic                 req_valid;
   logic                 req_ready;
   logic                 req_write;
   logic [ADDR_SIZE-1:0] req_addr;
   logic [WORD_SIZE-1:0] req_wdata;
   logic [LEN_SIZE-1:0]  req_len;

   logic                 resp_valid;
   logic                 resp_ready;
   logic [WORD_SIZE-1:0] resp_rdata;
   logic                 resp_last;

   logic [ADDR_SIZE-1:0] mem_addr;
   logic [WORD_SIZE-1:0] mem_wdata;
   logic                 mem_wen;
   logic [WORD_SIZE-1:0] mem_rdata;

   modport master (
      input  req_valid, req_write, req_addr, req_wdata, req_len, resp_ready, mem_rdata,
      output req_ready, resp_valid, resp_rdata, resp_last, mem_addr, mem_wdata, mem_wen
   );

   modport slave (
      output req_valid, req_write, req_addr, req_wdata, req_len, resp_ready, mem_rdata,
      input  req_ready, resp_valid, resp_rdata, resp_last, mem_addr, mem_wdata, mem_wen
   );

endinterface

// File: rtl/mem_requester.sv
// Sequences load/store requests onto a single-port word memory; all outputs registered.
// Define MEM_REQ_BURST_EN to honour req_len as a multi-word incrementing load burst.
module mem_requester
   import mem_requester_pkg::*;
(
   input logic              clk,
   input logic              rst_n,
   mem_requester_if.master  bus
);

   state_e state_q;

`ifdef MEM_REQ_BURST_EN
   logic [MEM_LEN_SIZE-1:0] cnt_q;
   logic                    last_word;
   assign last_word = (cnt_q == '0);
`else
   logic last_word;
   assign last_word = 1'b1;
`endif

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q         <= StIdle;
         bus.req_ready   <= 1'b1;
         bus.resp_valid  <= 1'b0;
         bus.resp_last   <= 1'b0;
         bus.resp_rdata  <= '0;
         bus.mem_addr    <= '0;
         bus.mem_wdata   <= '0;
         bus.mem_wen     <= 1'b0;
`ifdef MEM_REQ_BURST_EN
         cnt_q           <= '0;
`endif
      end else begin
         unique case (state_q)
            StIdle: begin
               if (bus.req_valid && bus.req_ready) begin
                  bus.mem_addr  <= bus.req_addr;
                  bus.mem_wdata <= bus.req_wdata;
                  bus.req_ready <= 1'b0;
`ifdef MEM_REQ_BURST_EN
                  cnt_q         <= bus.req_len;
`endif
                  if (bus.req_write == OP_STORE) begin
                     bus.mem_wen <= 1'b1;
                     state_q     <= StWrite;
                  end else begin
                     state_q     <= StRead;
                  end
               end
            end
            StWrite: begin
               bus.mem_wen   <= 1'b0;
               bus.req_ready <= 1'b1;
               state_q       <= StIdle;
            end
            StRead: begin
               bus.resp_rdata <= bus.mem_rdata;
               bus.resp_last  <= last_word;
               bus.resp_valid <= 1'b1;
               state_q        <= StResp;
            end
            StResp: begin
               if (bus.resp_ready) begin
                  bus.resp_valid <= 1'b0;
                  bus.resp_last  <= 1'b0;
                  if (last_word) begin
                     bus.req_ready <= 1'b1;
                     state_q       <= StIdle;
                  end
`ifdef MEM_REQ_BURST_EN
                  else begin
                     // Address wraps modulo the memory size by plain overflow.
                     cnt_q        <= cnt_q - MEM_LEN_SIZE'(1);
                     bus.mem_addr <= bus.mem_addr + MEM_ADDR_SIZE'(1);
                     state_q      <= StRead;
                  end
`endif
               end
            end
            default: state_q <= StIdle;
         endcase
      end
   end

endmodule

// File: tb/tb_mem_requester.sv
// Randomized self-checking bench for mem_requester against a word-array reference model.
module tb_mem_requester;
   import mem_requester_pkg::*;

`ifdef MEM_REQ_BURST_EN
   localparam bit BurstEn = 1'b1;
`else
   localparam bit BurstEn = 1'b0;
`endif

   logic clk;
   logic rst_n;
   logic preload;

   mem_requester_if bus ();

   mem_requester dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   // Memory the DUT talks to; the reference contents live separately in ref_mem.
   logic [31:0] mem_arr [32];
   assign bus.mem_rdata = mem_arr[bus.mem_addr];
   always @(posedge clk) begin
      if (preload) begin
         for (int i = 0; i < 32; i++) mem_arr[i] <= 32'(i);
      end else if (bus.mem_wen) begin
         mem_arr[bus.mem_addr] <= bus.mem_wdata;
      end
   end

   int n_accepts = 0;
   always @(posedge clk) begin
      if (rst_n && bus.req_valid && bus.req_ready) n_accepts <= n_accepts + 1;
   end

   logic [31:0] ref_mem [32];
   int n_checks = 0;
   int n_pass = 0;

   task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_checks++;
      if (got === exp) n_pass++;
      else $display("FAIL %s: got %0h expected %0h", tag, got, exp);
   endtask

   function automatic int words_for(input logic [2:0] len);
      return BurstEn ? int'(len) + 1 : 1;
   endfunction

   // Called at a negedge; returns at the negedge right after the accepting edge.
   task automatic issue(input logic wr, input logic [4:0] addr, input logic [31:0] data,
                        input logic [2:0] len);
      int t = 0;
      bus.req_valid = 1'b1;
      bus.req_write = wr;
      bus.req_addr  = addr;
      bus.req_wdata = data;
      bus.req_len   = len;
      while (!bus.req_ready && t < 20) begin
         @(negedge clk);
         t++;
      end
      check("req_ready_wait", bus.req_ready, 1);
      @(negedge clk);
      bus.req_valid = 1'b0;
   endtask

   task automatic do_store(input logic [4:0] addr, input logic [31:0] data);
      issue(OP_STORE, addr, data, 3'($urandom_range(0, 7)));
      check("st_wen_on", bus.mem_wen, 1);
      check("st_addr", bus.mem_addr, addr);
      check("st_wdata", bus.mem_wdata, data);
      check("st_busy", bus.req_ready, 0);
      @(negedge clk);
      check("st_wen_off", bus.mem_wen, 0);
      check("st_ready_back", bus.req_ready, 1);
      ref_mem[addr] = data;
   endtask

   task automatic do_load(input logic [4:0] addr, input logic [2:0] len, input int max_stall);
      int n = words_for(len);
      issue(OP_LOAD, addr, '0, len);
      check("ld_read_valid", bus.resp_valid, 0);
      check("ld_mem_addr", bus.mem_addr, addr);
      @(negedge clk);
      check("ld_latency", bus.resp_valid, 1);
      for (int i = 0; i < n; i++) begin
         int t = 0;
         int stall;
         logic [4:0] ea = 5'((int'(addr) + i) % 32);
         while (!bus.resp_valid && t < 20) begin
            @(negedge clk);
            t++;
         end
         check("ld_valid", bus.resp_valid, 1);
         check("ld_rdata", bus.resp_rdata, ref_mem[ea]);
         check("ld_last", bus.resp_last, (i == n - 1));
         stall = (max_stall == 0) ? 0 : $urandom_range(1, max_stall);
         repeat (stall) begin
            @(negedge clk);
            check("hold_valid", bus.resp_valid, 1);
            check("hold_rdata", bus.resp_rdata, ref_mem[ea]);
            check("hold_last", bus.resp_last, (i == n - 1));
            check("hold_addr", bus.mem_addr, ea);
         end
         bus.resp_ready = 1'b1;
         @(negedge clk);
         bus.resp_ready = 1'b0;
      end
      check("ld_done_ready", bus.req_ready, 1);
      check("ld_done_valid", bus.resp_valid, 0);
   endtask

   initial begin
      int t;
      int base;
      logic [4:0] a;
      logic [31:0] d;
      for (int i = 0; i < 32; i++) ref_mem[i] = 32'(i);
      rst_n = 1'b0;
      preload = 1'b1;
      bus.req_valid = 1'b0;
      bus.req_write = 1'b0;
      bus.req_addr = '0;
      bus.req_wdata = '0;
      bus.req_len = '0;
      bus.resp_ready = 1'b0;
      repeat (3) @(negedge clk);
      preload = 1'b0;
      rst_n = 1'b1;
      @(negedge clk);
      check("rst_req_ready", bus.req_ready, 1);
      check("rst_resp_valid", bus.resp_valid, 0);
      check("rst_mem_wen", bus.mem_wen, 0);
      check("rst_mem_addr", bus.mem_addr, 0);
      check("rst_resp_rdata", bus.resp_rdata, 0);
      check("rst_resp_last", bus.resp_last, 0);

      do_load(5'd7, 3'd0, 0);
      do_store(5'd3, 32'hDEADBEEF);
      do_load(5'd3, 3'd0, 0);
      // Wrapping burst with resp_ready toggling 0/1.
      do_load(5'd30, 3'd3, 1);

      // Reset while a response is being presented.
      issue(OP_LOAD, 5'd10, '0, 3'd2);
      @(negedge clk);
      check("rr_pre_valid", bus.resp_valid, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rr_valid_async", bus.resp_valid, 0);
      check("rr_ready_async", bus.req_ready, 1);
      check("rr_addr_async", bus.mem_addr, 0);
      @(negedge clk);
      rst_n = 1'b1;
      bus.resp_ready = 1'b1;
      repeat (6) begin
         @(negedge clk);
         check("rr_no_resp", bus.resp_valid, 0);
      end
      bus.resp_ready = 1'b0;

      // Reset during the write cycle loses the store.
      issue(OP_STORE, 5'd12, 32'h12345678, 3'd0);
      check("rw_wen_on", bus.mem_wen, 1);
      #2 rst_n = 1'b0;
      #1;
      check("rw_wen_async", bus.mem_wen, 0);
      @(negedge clk);
      rst_n = 1'b1;
      @(negedge clk);
      do_load(5'd12, 3'd0, 0);

      // Back-to-back store/load pairs with req_valid never dropped.
      base = n_accepts;
      bus.resp_ready = 1'b1;
      bus.req_valid = 1'b1;
      for (int k = 0; k < 8; k++) begin
         if (k % 2 == 0) begin
            a = 5'($urandom_range(0, 31));
            d = $urandom;
         end
         bus.req_write = (k % 2 == 0) ? OP_STORE : OP_LOAD;
         bus.req_addr = a;
         bus.req_wdata = d;
         bus.req_len = 3'd0;
         t = 0;
         while (!bus.req_ready && t < 20) begin
            @(negedge clk);
            t++;
         end
         check("b2b_ready", bus.req_ready, 1);
         @(negedge clk);
         if (k % 2 == 0) begin
            ref_mem[a] = d;
         end else begin
            t = 0;
            while (!bus.resp_valid && t < 20) begin
               @(negedge clk);
               t++;
            end
            check("b2b_rdata", bus.resp_rdata, ref_mem[a]);
         end
      end
      bus.req_valid = 1'b0;
      repeat (2) @(negedge clk);
      bus.resp_ready = 1'b0;
      check("b2b_accepts", n_accepts - base, 8);

      // Random mix of stores and (burst) loads with random backpressure.
      for (int k = 0; k < 24; k++) begin
         if ($urandom_range(0, 1) == 1) do_store(5'($urandom_range(0, 31)), $urandom);
         else do_load(5'($urandom_range(0, 31)), 3'($urandom_range(0, 7)), $urandom_range(0, 3));
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
